// File: rtl/pc_fetch_ctrl.sv
// Pre-IF fetch sequencer: drives the inst SRAM request/response port and
// hands {pc, inst} pairs to IF, discarding wrong-path fetches on redirect.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    input  logic            br_flag_i,
    input  logic [PC_W-1:0] br_pc_i,
    input  logic            if_allowin_i,
    output logic            inst_sram_req_o,
    output logic [PC_W-1:0] inst_sram_addr_o,
    input  logic            inst_sram_addr_ok_i,
    input  logic            inst_sram_data_ok_i,
    input  logic [31:0]     inst_sram_rdata_i,
    output logic            to_if_valid_o,
    output logic [PC_W-1:0] to_if_pc_o,
    output logic [31:0]     to_if_inst_o
);

    typedef enum logic [1:0] {
        RST_IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_r, pc_d;
    logic [PC_W-1:0] pend_pc_r, pend_pc_d;
    logic [31:0]     inst_buf, inst_d;
    logic            cancel_r, cancel_d;

    logic            redirect;
    logic [PC_W-1:0] redir_pc;

    assign redirect = flush_i | br_flag_i;
    assign redir_pc = flush_i ? flush_pc_i : br_pc_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_IDLE;
            pc_r      <= RESET_PC[PC_W-1:0];
            pend_pc_r <= '0;
            inst_buf  <= '0;
            cancel_r  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_r      <= pc_d;
            pend_pc_r <= pend_pc_d;
            inst_buf  <= inst_d;
            cancel_r  <= cancel_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_r;
        pend_pc_d       = pend_pc_r;
        inst_d          = inst_buf;
        cancel_d        = cancel_r;
        inst_sram_req_o = 1'b0;
        to_if_valid_o   = 1'b0;
        unique case (state_q)
            RST_IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // The request stays up even when redirected; its reply is
                // dropped later via cancel_r.
                inst_sram_req_o = 1'b1;
                if (redirect) begin
                    cancel_d  = 1'b1;
                    pend_pc_d = redir_pc;
                end
                if (inst_sram_addr_ok_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok_i) begin
                    cancel_d = 1'b0;
                    if (redirect) begin
                        pc_d    = redir_pc;
                        state_d = REQ;
                    end else if (cancel_r) begin
                        pc_d    = pend_pc_r;
                        state_d = REQ;
                    end else begin
                        inst_d  = inst_sram_rdata_i;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    cancel_d  = 1'b1;
                    pend_pc_d = redir_pc;
                end
            end
            HOLD: begin
                to_if_valid_o = !redirect;
                if (redirect) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (if_allowin_i) begin
                    pc_d    = pc_r + PC_W'(4);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = RST_IDLE;
            end
        endcase
    end

    // Address/pc buses read zero only while idling out of reset.
    assign inst_sram_addr_o = (state_q == RST_IDLE) ? '0 : pc_r;
    assign to_if_pc_o       = (state_q == RST_IDLE) ? '0 : pc_r;
    assign to_if_inst_o     = inst_buf;

endmodule
